arq_seqn_ctrl: RTL and testbench

Baseband ARQ/SEQN/FLOW controller, directly downstream of the packet header bit processor. Consumes decoded header results (HEC check, LT_ADDR match, packet type, SEQN, per-LT ARQN/FLOW) and the payload CRC verdict. Produces the per-LT_ADDR txaclSEQN/txARQN tables and rspFLOW that the header processor inserts into the next transmitted header. Also flags each received CRC payload as new or duplicate for the rx buffer.

---
 rtl/bt_pkt_pkg.sv | 34 +++
 rtl/arq_seqn_filter.sv | 40 ++++
 rtl/arq_seqn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arq_seqn_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkt_pkg.sv
// Shared baseband packet definitions: packet type codes, CRC-type test and ARQ FSM states.
package bt_pkt_pkg;

    localparam int unsigned LT_W  = 3;
    localparam int unsigned PKT_W = 4;

    localparam logic [PKT_W-1:0] PK_NULL = 4'b0000;
    localparam logic [PKT_W-1:0] PK_POLL = 4'b0001;
    localparam logic [PKT_W-1:0] PK_FHS  = 4'b0010;
    localparam logic [PKT_W-1:0] PK_DM1  = 4'b0011;
    localparam logic [PKT_W-1:0] PK_DH1  = 4'b0100;
    localparam logic [PKT_W-1:0] PK_HV1  = 4'b0101;
    localparam logic [PKT_W-1:0] PK_DV   = 4'b1000;
    localparam logic [PKT_W-1:0] PK_AUX1 = 4'b1001;
    localparam logic [PKT_W-1:0] PK_DM3  = 4'b1010;
    localparam logic [PKT_W-1:0] PK_DH3  = 4'b1011;
    localparam logic [PKT_W-1:0] PK_DM5  = 4'b1110;
    localparam logic [PKT_W-1:0] PK_DH5  = 4'b1111;

    typedef enum logic [1:0] {
        ARQ_IDLE     = 2'd0,
        ARQ_HDR_WAIT = 2'd1,
        ARQ_PY_WAIT  = 2'd2
    } arq_state_e;

    // Only CRC-protected payload types take part in ARQ.
    function automatic logic is_crc_type(input logic [PKT_W-1:0] t);
        case (t)
            PK_DM1, PK_DH1, PK_DV, PK_DM3, PK_DH3, PK_DM5, PK_DH5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arq_seqn_filter.sv
// Per-LT last-accepted SEQN store with combinational new/duplicate verdict.
module arq_seqn_filter
    import bt_pkt_pkg::*;
#(
    parameter int unsigned NUM_LT = 8
)(
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            clr_i,
    input  logic [LT_W-1:0] lt_i,
    input  logic            seqn_i,
    input  logic            upd_i,
    output logic            is_new_c
);

    logic [NUM_LT-1:0] old_q, old_d;
    logic [NUM_LT-1:0] valid_q, valid_d;

    always_comb begin
        old_d   = old_q;
        valid_d = valid_q;
        if (upd_i) begin
            old_d[lt_i]   = seqn_i;
            valid_d[lt_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (!rstz || clr_i) begin
            old_q   <= '0;
            valid_q <= '0;
        end else begin
            old_q   <= old_d;
            valid_q <= valid_d;
        end
    end

    assign is_new_c = !valid_q[lt_i] || (old_q[lt_i] != seqn_i);

endmodule

// File: rtl/arq_seqn_ctrl.sv
// ARQ/SEQN/FLOW controller: maintains per-LT tx SEQN and ARQN tables and classifies rx payloads.
module arq_seqn_ctrl
    import bt_pkt_pkg::*;
#(
    parameter int unsigned NUM_LT    = 8,
    parameter logic        SEQN_INIT = 1'b1
)(
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              p_1us,
    input  logic              s_2active_p,
    input  logic              m_2active_p,
    input  logic              conns,
    input  logic              pk_encode,
    input  logic              ms_tslot_p,
    input  logic              tx_packet_st_p,
    input  logic [LT_W-1:0]   txpk_lt_addr,
    input  logic [PKT_W-1:0]  txpktype,
    input  logic              rx_trailer_st_p,
    input  logic              ckheader_endp,
    input  logic              dec_hecgood,
    input  logic              lt_addressed,
    input  logic [LT_W-1:0]   dec_lt_addr,
    input  logic [PKT_W-1:0]  dec_pk_type,
    input  logic              dec_seqn,
    input  logic [NUM_LT-1:0] dec_arqn,
    input  logic              rx_crc_endp,
    input  logic              dec_crcgood,
    input  logic              rxbuf_full,
    output logic [NUM_LT-1:0] txaclSEQN,
    output logic [NUM_LT-1:0] txARQN,
    output logic              rspFLOW,
    output logic              rx_new_p,
    output logic              rx_dup_p,
    output logic              tx_ack_p,
    output logic [LT_W-1:0]   ack_lt_addr,
    output logic [1:0]        arq_state
);

    arq_state_e        state_q, state_d;
    logic [NUM_LT-1:0] seqn_q, seqn_d, arqn_q, arqn_d, pend_q, pend_d;
    logic [LT_W-1:0]   lt_q, lt_d, ack_lt_q, ack_lt_d;
    logic              rseqn_q, rseqn_d, flow_q, flow_d;
    logic              rx_new_q, rx_new_d, rx_dup_q, rx_dup_d, tx_ack_q, tx_ack_d;
    logic              filt_upd, is_new_c;

    logic new_conn, tx_ev, trl_ev, hdr_ev, crc_ev, slot_ev, hdr_ok;
    assign new_conn = (s_2active_p | m_2active_p) & p_1us;
    assign tx_ev    = tx_packet_st_p & p_1us & pk_encode & conns;
    assign trl_ev   = rx_trailer_st_p & p_1us & !pk_encode & conns;
    assign hdr_ev   = ckheader_endp & p_1us;
    assign crc_ev   = rx_crc_endp & p_1us;
    assign slot_ev  = ms_tslot_p & p_1us;
    assign hdr_ok   = dec_hecgood & lt_addressed;

    arq_seqn_filter #(.NUM_LT(NUM_LT)) u_filter (
        .clk_6M   (clk_6M),
        .rstz     (rstz),
        .clr_i    (new_conn),
        .lt_i     (lt_q),
        .seqn_i   (rseqn_q),
        .upd_i    (filt_upd),
        .is_new_c (is_new_c)
    );

    always_comb begin
        state_d  = state_q;
        seqn_d   = seqn_q;
        arqn_d   = arqn_q;
        pend_d   = pend_q;
        lt_d     = lt_q;
        rseqn_d  = rseqn_q;
        ack_lt_d = ack_lt_q;
        flow_d   = !rxbuf_full;
        rx_new_d = 1'b0;
        rx_dup_d = 1'b0;
        tx_ack_d = 1'b0;
        filt_upd = 1'b0;

        if (tx_ev && is_crc_type(txpktype))
            pend_d[txpk_lt_addr] = 1'b1;

        // Peer ACK of our pending packet advances that LT's SEQN.
        if (hdr_ev && !pk_encode && hdr_ok && pend_q[dec_lt_addr] && dec_arqn[dec_lt_addr]) begin
            seqn_d[dec_lt_addr] = !seqn_q[dec_lt_addr];
            pend_d[dec_lt_addr] = 1'b0;
            tx_ack_d            = 1'b1;
            ack_lt_d            = dec_lt_addr;
        end

        if (!conns) begin
            state_d = ARQ_IDLE;
        end else begin
            case (state_q)
                ARQ_IDLE: begin
                    if (trl_ev) state_d = ARQ_HDR_WAIT;
                end
                ARQ_HDR_WAIT: begin
                    if (hdr_ev) begin
                        state_d = ARQ_IDLE;
                        if (hdr_ok && is_crc_type(dec_pk_type)) begin
                            lt_d    = dec_lt_addr;
                            rseqn_d = dec_seqn;
                            state_d = ARQ_PY_WAIT;
                        end else if (!hdr_ok) begin
                            arqn_d[txpk_lt_addr] = 1'b0;
                        end
                    end else if (slot_ev) begin
                        arqn_d[txpk_lt_addr] = 1'b0;
                        state_d              = ARQ_IDLE;
                    end
                end
                ARQ_PY_WAIT: begin
                    // CRC verdict takes precedence over a coincident slot boundary.
                    if (crc_ev) begin
                        state_d = ARQ_IDLE;
                        if (!dec_crcgood) begin
                            arqn_d[lt_q] = 1'b0;
                        end else if (!is_new_c) begin
                            arqn_d[lt_q] = 1'b1;
                            rx_dup_d     = 1'b1;
                            ack_lt_d     = lt_q;
                        end else if (rxbuf_full) begin
                            arqn_d[lt_q] = 1'b0;
                        end else begin
                            arqn_d[lt_q] = 1'b1;
                            filt_upd     = 1'b1;
                            rx_new_d     = 1'b1;
                            ack_lt_d     = lt_q;
                        end
                    end else if (slot_ev) begin
                        arqn_d[lt_q] = 1'b0;
                        state_d      = ARQ_IDLE;
                    end
                end
                default: state_d = ARQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M) begin
        if (!rstz || new_conn) begin
            state_q  <= ARQ_IDLE;
            seqn_q   <= {NUM_LT{SEQN_INIT}};
            arqn_q   <= '0;
            pend_q   <= '0;
            lt_q     <= '0;
            rseqn_q  <= 1'b0;
            ack_lt_q <= '0;
            flow_q   <= 1'b1;
            rx_new_q <= 1'b0;
            rx_dup_q <= 1'b0;
            tx_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seqn_q   <= seqn_d;
            arqn_q   <= arqn_d;
            pend_q   <= pend_d;
            lt_q     <= lt_d;
            rseqn_q  <= rseqn_d;
            ack_lt_q <= ack_lt_d;
            flow_q   <= flow_d;
            rx_new_q <= rx_new_d;
            rx_dup_q <= rx_dup_d;
            tx_ack_q <= tx_ack_d;
        end
    end

    assign txaclSEQN   = seqn_q;
    assign txARQN      = arqn_q;
    assign rspFLOW     = flow_q;
    assign rx_new_p    = rx_new_q;
    assign rx_dup_p    = rx_dup_q;
    assign tx_ack_p    = tx_ack_q;
    assign ack_lt_addr = ack_lt_q;
    assign arq_state   = 2'(state_q);

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Bench for arq_seqn_ctrl: vector table for rx payload handling plus hand-written corner sequences.
module tb_arq_seqn_ctrl;
    import bt_pkt_pkg::*;

    logic       clk_6M = 1'b0;
    logic       rstz = 1'b0, p_1us = 1'b1, s_2active_p = 1'b0, m_2active_p = 1'b0;
    logic       conns = 1'b1, pk_encode = 1'b0, ms_tslot_p = 1'b0, tx_packet_st_p = 1'b0;
    logic [2:0] txpk_lt_addr = 3'd0;
    logic [3:0] txpktype = 4'd0;
    logic       rx_trailer_st_p = 1'b0, ckheader_endp = 1'b0, dec_hecgood = 1'b0, lt_addressed = 1'b0;
    logic [2:0] dec_lt_addr = 3'd0;
    logic [3:0] dec_pk_type = 4'd0;
    logic       dec_seqn = 1'b0;
    logic [7:0] dec_arqn = 8'd0;
    logic       rx_crc_endp = 1'b0, dec_crcgood = 1'b0, rxbuf_full = 1'b0;
    logic [7:0] txaclSEQN, txARQN;
    logic       rspFLOW, rx_new_p, rx_dup_p, tx_ack_p;
    logic [2:0] ack_lt_addr;
    logic [1:0] arq_state;

    arq_seqn_ctrl dut (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .s_2active_p(s_2active_p),
        .m_2active_p(m_2active_p), .conns(conns), .pk_encode(pk_encode), .ms_tslot_p(ms_tslot_p),
        .tx_packet_st_p(tx_packet_st_p), .txpk_lt_addr(txpk_lt_addr), .txpktype(txpktype),
        .rx_trailer_st_p(rx_trailer_st_p), .ckheader_endp(ckheader_endp), .dec_hecgood(dec_hecgood),
        .lt_addressed(lt_addressed), .dec_lt_addr(dec_lt_addr), .dec_pk_type(dec_pk_type),
        .dec_seqn(dec_seqn), .dec_arqn(dec_arqn), .rx_crc_endp(rx_crc_endp), .dec_crcgood(dec_crcgood),
        .rxbuf_full(rxbuf_full), .txaclSEQN(txaclSEQN), .txARQN(txARQN), .rspFLOW(rspFLOW),
        .rx_new_p(rx_new_p), .rx_dup_p(rx_dup_p), .tx_ack_p(tx_ack_p), .ack_lt_addr(ack_lt_addr),
        .arq_state(arq_state)
    );

    always #5 clk_6M = ~clk_6M;

    int total = 0;
    int bad = 0;

    localparam logic [2:0] K_NEW = 3'b001, K_DUP = 3'b010, K_ACK = 3'b100;
    typedef struct packed { logic [2:0] kind; logic [2:0] lt; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0] lt; logic [3:0] typ; logic sq; logic good; logic full;
        logic [2:0] kind; logic [7:0] arqn; logic flow;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic crc_t(input logic [3:0] t);
        return t inside {4'd3, 4'd4, 4'd8, 4'd10, 4'd11, 4'd14, 4'd15};
    endfunction

    task automatic expect_p(input logic [2:0] kind, input logic [2:0] lt);
        exp_t e;
        e.kind = kind;
        e.lt   = lt;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every output pulse must match the next queued expectation.
    always @(negedge clk_6M) begin
        if (tx_ack_p || rx_dup_p || rx_new_p) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got ack/dup/new=%b lt=%0d want none", {tx_ack_p, rx_dup_p, rx_new_p}, ack_lt_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", 32'({tx_ack_p, rx_dup_p, rx_new_p}), 32'(e.kind));
                chk("pulse_lt", 32'(ack_lt_addr), 32'(e.lt));
            end
        end
    end

    task automatic clk1();
        @(posedge clk_6M);
        @(negedge clk_6M);
    endtask

    task automatic do_tx(input logic [2:0] lt, input logic [3:0] t);
        pk_encode = 1'b1; tx_packet_st_p = 1'b1; txpk_lt_addr = lt; txpktype = t;
        clk1();
        tx_packet_st_p = 1'b0; pk_encode = 1'b0;
    endtask

    task automatic rx_hdr(input logic [2:0] lt, input logic [3:0] t, input logic sq,
                          input logic [7:0] arqn, input logic hec, input logic addr);
        rx_trailer_st_p = 1'b1;
        clk1();
        rx_trailer_st_p = 1'b0;
        chk("hdr_wait_state", 32'(arq_state), 32'd1);
        ckheader_endp = 1'b1; dec_lt_addr = lt; dec_pk_type = t; dec_seqn = sq;
        dec_arqn = arqn; dec_hecgood = hec; lt_addressed = hec & addr;
        clk1();
        ckheader_endp = 1'b0; dec_arqn = 8'd0; dec_hecgood = 1'b0; lt_addressed = 1'b0;
        chk("post_hdr_state", 32'(arq_state), (hec && addr && crc_t(t)) ? 32'd2 : 32'd0);
    endtask

    task automatic rx_crc(input logic good, input logic slot);
        rx_crc_endp = 1'b1; dec_crcgood = good; ms_tslot_p = slot;
        clk1();
        rx_crc_endp = 1'b0; ms_tslot_p = 1'b0; dec_crcgood = 1'b0;
        chk("post_crc_state", 32'(arq_state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'd2, PK_DH1, 1'b0, 1'b1, 1'b0, K_NEW, 8'h04, 1'b1};
        tbl[1]  = '{3'd2, PK_DH1, 1'b0, 1'b1, 1'b0, K_DUP, 8'h04, 1'b1};
        tbl[2]  = '{3'd2, PK_DH1, 1'b1, 1'b1, 1'b0, K_NEW, 8'h04, 1'b1};
        tbl[3]  = '{3'd3, PK_DM1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h04, 1'b1};
        tbl[4]  = '{3'd3, PK_DM5, 1'b0, 1'b1, 1'b0, K_NEW, 8'h0c, 1'b1};
        tbl[5]  = '{3'd3, PK_DH5, 1'b0, 1'b1, 1'b0, K_DUP, 8'h0c, 1'b1};
        tbl[6]  = '{3'd3, PK_DV,  1'b1, 1'b0, 1'b0, 3'b000, 8'h04, 1'b1};
        tbl[7]  = '{3'd4, PK_DM3, 1'b1, 1'b1, 1'b1, 3'b000, 8'h04, 1'b0};
        tbl[8]  = '{3'd4, PK_DH3, 1'b1, 1'b1, 1'b0, K_NEW, 8'h14, 1'b1};
        tbl[9]  = '{3'd4, PK_DH3, 1'b1, 1'b1, 1'b1, K_DUP, 8'h14, 1'b0};
        tbl[10] = '{3'd0, PK_DM1, 1'b0, 1'b1, 1'b0, K_NEW, 8'h15, 1'b1};
        tbl[11] = '{3'd7, PK_DH5, 1'b1, 1'b1, 1'b0, K_NEW, 8'h95, 1'b1};

        @(negedge clk_6M);
        clk1();
        rstz = 1'b1;
        chk("rst_seqn", 32'(txaclSEQN), 32'h0ff);
        chk("rst_arqn", 32'(txARQN), 32'h0);
        chk("rst_flow", 32'(rspFLOW), 32'd1);
        chk("rst_state", 32'(arq_state), 32'd0);
        chk("rst_ack_lt", 32'(ack_lt_addr), 32'd0);

        // Tx DM1 on LT1 acknowledged by peer.
        do_tx(3'd1, PK_DM1);
        expect_p(K_ACK, 3'd1);
        rx_hdr(3'd1, PK_NULL, 1'b0, 8'h02, 1'b1, 1'b1);
        chk("ack_seqn", 32'(txaclSEQN), 32'h0fd);
        chk("ack_arqn", 32'(txARQN), 32'h0);
        // NAK keeps SEQN and pending; a later ACK still lands.
        do_tx(3'd1, PK_DM1);
        rx_hdr(3'd1, PK_NULL, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("nak_seqn", 32'(txaclSEQN), 32'h0fd);
        expect_p(K_ACK, 3'd1);
        rx_hdr(3'd1, PK_NULL, 1'b0, 8'h02, 1'b1, 1'b1);
        chk("late_ack_seqn", 32'(txaclSEQN), 32'h0ff);
        // Non-CRC tx type is never pending.
        do_tx(3'd5, PK_POLL);
        rx_hdr(3'd5, PK_NULL, 1'b0, 8'h20, 1'b1, 1'b1);
        chk("poll_no_ack_seqn", 32'(txaclSEQN), 32'h0ff);
        // Events without p_1us are ignored.
        p_1us = 1'b0; rx_trailer_st_p = 1'b1;
        clk1();
        rx_trailer_st_p = 1'b0; p_1us = 1'b1;
        chk("no_strobe_state", 32'(arq_state), 32'd0);

        for (int i = 0; i < 12; i++) begin
            rxbuf_full = tbl[i].full;
            rx_hdr(tbl[i].lt, tbl[i].typ, tbl[i].sq, 8'h00, 1'b1, 1'b1);
            if (tbl[i].kind != 3'b000) expect_p(tbl[i].kind, tbl[i].lt);
            rx_crc(tbl[i].good, 1'b0);
            chk($sformatf("vec%0d_arqn", i), 32'(txARQN), 32'(tbl[i].arqn));
            chk($sformatf("vec%0d_flow", i), 32'(rspFLOW), 32'(tbl[i].flow));
            chk($sformatf("vec%0d_seqn", i), 32'(txaclSEQN), 32'h0ff);
        end
        rxbuf_full = 1'b0;
        clk1();

        // rspFLOW follows rxbuf_full one clock later.
        rxbuf_full = 1'b1;
        chk("flow_before_edge", 32'(rspFLOW), 32'd1);
        clk1();
        chk("flow_after_edge", 32'(rspFLOW), 32'd0);
        rxbuf_full = 1'b0;
        clk1();

        // Slot boundary in HDR_WAIT, then bad-addressing header, both clear txARQN[txpk_lt_addr].
        do_tx(3'd6, PK_DM1);
        rx_hdr(3'd6, PK_DM1, 1'b0, 8'h00, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd6);
        rx_crc(1'b1, 1'b0);
        chk("lt6_arqn", 32'(txARQN), 32'h0d5);
        rx_trailer_st_p = 1'b1;
        clk1();
        rx_trailer_st_p = 1'b0;
        chk("slot_hdr_wait", 32'(arq_state), 32'd1);
        ms_tslot_p = 1'b1;
        clk1();
        ms_tslot_p = 1'b0;
        chk("slot_hdr_state", 32'(arq_state), 32'd0);
        chk("slot_hdr_arqn", 32'(txARQN), 32'h095);
        rx_hdr(3'd6, PK_DM1, 1'b1, 8'h00, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd6);
        rx_crc(1'b1, 1'b0);
        rx_hdr(3'd6, PK_DM1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("not_addr_arqn", 32'(txARQN), 32'h095);

        // Slot boundary in PY_WAIT clears txARQN[L]; coincident CRC wins.
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        ms_tslot_p = 1'b1;
        clk1();
        ms_tslot_p = 1'b0;
        chk("slot_py_state", 32'(arq_state), 32'd0);
        chk("slot_py_arqn", 32'(txARQN), 32'h091);
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd2);
        rx_crc(1'b1, 1'b1);
        chk("crc_wins_arqn", 32'(txARQN), 32'h095);

        // Dropping the connection forces IDLE.
        rx_trailer_st_p = 1'b1;
        clk1();
        rx_trailer_st_p = 1'b0; conns = 1'b0;
        clk1();
        conns = 1'b1;
        chk("conns_drop_state", 32'(arq_state), 32'd0);
        chk("conns_drop_arqn", 32'(txARQN), 32'h095);

        // New connection mid PY_WAIT.
        do_tx(3'd1, PK_DM1);
        expect_p(K_ACK, 3'd1);
        rx_hdr(3'd1, PK_NULL, 1'b0, 8'h02, 1'b1, 1'b1);
        chk("pre_nc_seqn", 32'(txaclSEQN), 32'h0fd);
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        m_2active_p = 1'b1;
        clk1();
        m_2active_p = 1'b0;
        chk("nc_state", 32'(arq_state), 32'd0);
        chk("nc_seqn", 32'(txaclSEQN), 32'h0ff);
        chk("nc_arqn", 32'(txARQN), 32'h0);
        chk("nc_flow", 32'(rspFLOW), 32'd1);
        chk("nc_ack_lt", 32'(ack_lt_addr), 32'd0);
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd2);
        rx_crc(1'b1, 1'b0);
        chk("nc_new_arqn", 32'(txARQN), 32'h004);

        // Reset pulse mid PY_WAIT.
        do_tx(3'd1, PK_DM1);
        expect_p(K_ACK, 3'd1);
        rx_hdr(3'd1, PK_NULL, 1'b0, 8'h02, 1'b1, 1'b1);
        do_tx(3'd5, PK_DH1);
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        rstz = 1'b0;
        clk1();
        rstz = 1'b1;
        chk("rp_state", 32'(arq_state), 32'd0);
        chk("rp_seqn", 32'(txaclSEQN), 32'h0ff);
        chk("rp_arqn", 32'(txARQN), 32'h0);
        rx_hdr(3'd2, PK_DH1, 1'b0, 8'h00, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd2);
        rx_crc(1'b1, 1'b0);
        rx_hdr(3'd5, PK_NULL, 1'b0, 8'h20, 1'b1, 1'b1);
        chk("rp_pend_clr_seqn", 32'(txaclSEQN), 32'h0ff);

        // Tx ACK and rx new in one header/payload sequence.
        do_tx(3'd3, PK_DH1);
        expect_p(K_ACK, 3'd3);
        rx_hdr(3'd3, PK_DH1, 1'b1, 8'h08, 1'b1, 1'b1);
        expect_p(K_NEW, 3'd3);
        rx_crc(1'b1, 1'b0);
        chk("both_seqn", 32'(txaclSEQN), 32'h0f7);
        chk("both_arqn", 32'(txARQN), 32'h00c);

        clk1();
        clk1();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
